// File: rtl/fifo_rr_scheduler.sv
// Round-robin scheduler draining four VC source FIFOs into two egress FIFOs.
// A pop is pushed to the destination chosen by the word's DEST_BIT exactly two cycles later.
module fifo_rr_scheduler #(
  parameter int DATA_SIZE = 10,
  parameter int DEST_BIT  = 8,
  parameter int NUM_SRC   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_SRC-1:0]           src_empty,
  input  logic [NUM_SRC*DATA_SIZE-1:0] src_data,
  input  logic [1:0]                   dst_pause,
  input  logic [1:0]                   dst_full,
  output logic [NUM_SRC-1:0]           src_pop,
  output logic [1:0]                   dst_push,
  output logic [DATA_SIZE-1:0]         dst_data,
  output logic [1:0]                   state,
  output logic                         idle,
  output logic                         error
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARB   = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  logic [1:0]           state_r;
  logic [1:0]           state_nxt_s;
  logic [1:0]           ptr_r;
  logic                 v1_r;
  logic [1:0]           idx1_r;
  logic [1:0]           push_r;
  logic [DATA_SIZE-1:0] data_r;
  logic                 error_r;

  logic [NUM_SRC-1:0]   req_s;
  logic                 any_req_s;
  logic                 pause_any_s;
  logic                 can_pop_s;
  logic [NUM_SRC-1:0]   grant_s;
  logic [1:0]           grant_idx_s;
  logic [DATA_SIZE-1:0] cap_word_s;
  logic                 cap_dest_s;

  assign req_s       = ~src_empty;
  assign any_req_s   = |req_s;
  assign pause_any_s = |dst_pause;
  assign can_pop_s   = reset & (state_r == ARB) & enable & ~pause_any_s & any_req_s;
  assign cap_word_s  = src_data[idx1_r*DATA_SIZE +: DATA_SIZE];
  assign cap_dest_s  = cap_word_s[DEST_BIT];

  // First requester at or after ptr_r, wrapping modulo four
  always_comb begin
    logic       found;
    logic       hit;
    logic [1:0] j;
    grant_s     = '0;
    grant_idx_s = ptr_r;
    found       = 1'b0;
    hit         = 1'b0;
    j           = 2'd0;
    for (int k = 0; k < 4; k++) begin
      j            = ptr_r + 2'(k);
      hit          = req_s[j] & ~found;
      grant_s[j]   = grant_s[j] | hit;
      grant_idx_s  = hit ? j : grant_idx_s;
      found        = found | hit;
    end
  end

  // Next-state logic; an empty request set wins over pause in ARB
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable && any_req_s && !pause_any_s) state_nxt_s = ARB;
        else                                      state_nxt_s = IDLE;
      end
      ARB: begin
        if (!enable || !any_req_s) state_nxt_s = IDLE;
        else if (pause_any_s)      state_nxt_s = STALL;
        else                       state_nxt_s = ARB;
      end
      STALL: begin
        if (!enable)           state_nxt_s = IDLE;
        else if (!pause_any_s) state_nxt_s = ARB;
        else                   state_nxt_s = STALL;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, pointer, pop stage and capture/push stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      ptr_r   <= 2'd0;
      v1_r    <= 1'b0;
      idx1_r  <= 2'd0;
      push_r  <= 2'b00;
      data_r  <= '0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= can_pop_s ? grant_idx_s + 2'd1 : ptr_r;
      v1_r    <= can_pop_s;
      idx1_r  <= grant_idx_s;
      if (v1_r && !dst_full[cap_dest_s]) begin
        push_r <= cap_dest_s ? 2'b10 : 2'b01;
        data_r <= cap_word_s;
      end else begin
        push_r <= 2'b00;
        data_r <= data_r;
      end
      // A full destination at capture time drops the word and latches the error
      error_r <= error_r | (v1_r & dst_full[cap_dest_s]);
    end
  end

  assign src_pop  = can_pop_s ? grant_s : '0;
  assign dst_push = push_r;
  assign dst_data = data_r;
  assign state    = state_r;
  assign error    = error_r;
  assign idle     = ~reset | ((state_r == IDLE) & ~v1_r & ~|push_r);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: behavioural source FIFOs plus a cycle-level
// reference model of the scheduling rules, with directed and random phases.
module tb_fifo_rr_scheduler;

  localparam int DW  = 10;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [3:0]    src_empty;
  logic [4*DW-1:0] src_data;
  logic [1:0]    dst_pause;
  logic [1:0]    dst_full;
  logic [3:0]    src_pop;
  logic [1:0]    dst_push;
  logic [DW-1:0] dst_data;
  logic [1:0]    state;
  logic          idle;
  logic          error;

  always #5 clk = ~clk;

  fifo_rr_scheduler #(.DATA_SIZE(DW), .DEST_BIT(DB), .NUM_SRC(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .src_empty(src_empty), .src_data(src_data),
    .dst_pause(dst_pause), .dst_full(dst_full),
    .src_pop(src_pop), .dst_push(dst_push), .dst_data(dst_data),
    .state(state), .idle(idle), .error(error)
  );

  // Source FIFOs: contents and registered pop data
  logic [DW-1:0] srcq [4][$];
  logic [DW-1:0] src_out [4];

  // Reference model
  int            m_state;
  int            m_ptr;
  bit            m_pv;
  logic [DW-1:0] m_pw;
  logic [1:0]    m_push;
  logic [DW-1:0] m_data;
  bit            m_err;
  bit            reset_seen = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < 4; i++) begin
      src_empty[i]          = (srcq[i].size() == 0);
      src_data[i*DW +: DW]  = src_out[i];
    end
  endtask

  task automatic load(input int s, input logic [DW-1:0] w);
    if (srcq[s].size() < 8) srcq[s].push_back(w);
    drive_src();
  endtask

  task automatic step();
    logic [3:0] req;
    logic [3:0] epop;
    logic [3:0] dut_pop;
    bit         pz;
    int         g;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) req[i] = (srcq[i].size() != 0);
    pz   = |dst_pause;
    epop = 4'b0000;
    g    = 0;
    if (reset && m_state == 1 && enable && !pz && req != 4'b0000) begin
      for (int k = 3; k >= 0; k--) if (req[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      epop = 4'b0001 << g;
    end
    check("src_pop", 32'(src_pop), 32'(epop));
    check("idle", 32'(idle), (!reset) ? 32'd1 : 32'(m_state == 0 && !m_pv && m_push == 2'b00));
    if (reset_seen) begin
      check("dst_push", 32'(dst_push), 32'(m_push));
      check("dst_data", 32'(dst_data), 32'(m_data));
      check("state", 32'(state), 32'(m_state));
      check("error", 32'(error), 32'(m_err));
    end
    dut_pop = src_pop;
    if (!reset) begin
      m_state = 0; m_ptr = 0; m_pv = 1'b0; m_pw = '0;
      m_push = 2'b00; m_data = '0; m_err = 1'b0;
      reset_seen = 1'b1;
    end else begin
      m_push = 2'b00;
      if (m_pv) begin
        if (dst_full[m_pw[DB]]) m_err = 1'b1;
        else begin
          m_push = m_pw[DB] ? 2'b10 : 2'b01;
          m_data = m_pw;
        end
      end
      m_pv = (epop != 4'b0000);
      if (m_pv) begin
        m_pw  = srcq[g][0];
        m_ptr = (g + 1) % 4;
      end
      case (m_state)
        0: if (enable && req != 4'b0000 && !pz) m_state = 1;
        1: begin
          if (!enable || req == 4'b0000) m_state = 0;
          else if (pz)                   m_state = 2;
        end
        2: begin
          if (!enable)  m_state = 0;
          else if (!pz) m_state = 1;
        end
        default: m_state = 0;
      endcase
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (dut_pop[i] && srcq[i].size() != 0) src_out[i] = srcq[i].pop_front();
    drive_src();
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    enable = 1'b0;
    dst_pause = 2'b00;
    dst_full  = 2'b00;
    for (int i = 0; i < 4; i++) srcq[i].delete();
    drive_src();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; dst_pause = 2'b00; dst_full = 2'b00;
    for (int i = 0; i < 4; i++) src_out[i] = 10'($urandom);
    drive_src();

    // Reset and quiet idle
    repeat (3) step();
    reset = 1'b1;
    repeat (3) step();

    // One word per source, alternating destinations
    load(0, 10'h001); load(1, 10'h102); load(2, 10'h003); load(3, 10'h104);
    enable = 1'b1;
    repeat (10) step();

    // Two active sources alternate
    do_reset();
    for (int n = 0; n < 3; n++) begin
      load(1, 10'($urandom));
      load(3, 10'($urandom));
    end
    enable = 1'b1;
    repeat (12) step();

    // Continuous traffic with a pause window
    do_reset();
    for (int n = 0; n < 6; n++)
      for (int i = 0; i < 4; i++) load(i, 10'($urandom));
    enable = 1'b1;
    repeat (4) step();
    dst_pause = 2'b01;
    repeat (5) step();
    dst_pause = 2'b00;
    repeat (24) step();

    // Drop on full destination, later words pass
    do_reset();
    load(0, 10'h100); load(1, 10'h0AA); load(2, 10'h1BB);
    enable = 1'b1;
    dst_full = 2'b10;
    repeat (4) step();
    dst_full = 2'b00;
    repeat (6) step();

    // Enable dropped right after a pop, then reset mid-stream
    do_reset();
    load(0, 10'($urandom)); load(1, 10'($urandom));
    enable = 1'b1;
    step(); step();
    enable = 1'b0;
    repeat (5) step();
    for (int n = 0; n < 5; n++)
      for (int i = 0; i < 4; i++) load(i, 10'($urandom));
    enable = 1'b1;
    repeat (6) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (12) step();

    // Randomized traffic and flow control
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) load($urandom_range(0, 3), 10'($urandom));
      enable    = ($urandom_range(0, 9) != 0);
      dst_pause = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      dst_full  = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 199) == 0) reset = 1'b0;
      else                             reset = 1'b1;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
